// File: rtl/crc9_pkg.sv
// Shared definitions for the crc9 divider and its sequencer.
// Exports: POLY (low-order taps of x^9+x^4+1), ctrl_state_t (sequencer states),
//          nshift() (total divider shifts for an n-bit message incl. 9 flush zeros).
package crc9_pkg;

  // x^9 is implicit in the 9-bit register; only the x^4 and x^0 taps remain.
  localparam logic [8:0] POLY = 9'h011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } ctrl_state_t;

  function automatic int nshift(input int n);
    return n + 9;
  endfunction

endpackage

// File: rtl/crc9_div.sv
// Serial polynomial divider for p(x)=x^9+x^4+1, message MSB first then zeros.
// Ports: clk, rst (async active-high, also driven by the sequencer's clear pulse),
//        shift (one bit per strobe), data (message), count (strobes taken), rem (remainder).
module crc9_div
  import crc9_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic [N-1:0]  data,
  output logic [CW-1:0] count,
  output logic [8:0]    rem
);

  // Shifting the message left by the count puts the next bit at the top;
  // once count reaches N the shifted value is all zeros, giving the flush bits.
  logic [N-1:0] data_sh;
  logic         din;

  assign data_sh = data << count;
  assign din     = data_sh[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rem   <= '0;
    end else if (shift) begin
      count <= count + CW'(1);
      rem   <= {rem[7:0], din} ^ (rem[8] ? POLY : 9'h000);
    end
  end

endmodule

// File: rtl/crc9_div_ctrl.sv
// Sequencer for the crc9 serial divider: accept a message, clear, issue N+9 shifts, capture.
// Ports: req_* (message in, valid/ready), res_* (remainder out, valid/ready), stall/abort
//        controls, busy, div_* (registered controls to the divider and its count/remainder back).
module crc9_div_ctrl
  import crc9_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_data,
  input  logic          stall,
  input  logic          abort,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [8:0]    res_rem,
  output logic          res_zero,
  output logic          res_err,
  output logic          busy,
  output logic          div_clr,
  output logic          div_shift,
  output logic [N-1:0]  div_data,
  input  logic [CW-1:0] div_count,
  input  logic [8:0]    div_rem
);

  localparam int NSHIFT = nshift(N);
  localparam logic [CW-1:0] NSHIFT_C = CW'(NSHIFT);

  ctrl_state_t   state;
  // Number of strobes issued so far, including the one currently on div_shift.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      div_clr   <= 1'b0;
      div_shift <= 1'b0;
      div_data  <= '0;
      res_valid <= 1'b0;
      res_rem   <= '0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      // Strobe and clear are single-cycle unless re-issued below.
      div_clr   <= 1'b0;
      div_shift <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            div_data  <= req_data;
            cnt       <= '0;
            div_clr   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CLEAR;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            // Abort leaves the divider cleared for the next message.
            div_clr   <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_SHIFT;
            if (!stall) begin
              div_shift <= 1'b1;
              cnt       <= CW'(1);
            end
          end
        end
        S_SHIFT: begin
          // Abort outranks stall; stall freezes count and state with no strobe.
          if (abort) begin
            div_clr   <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (!stall) begin
            if (cnt == NSHIFT_C) begin
              state <= S_CAPTURE;
            end else begin
              div_shift <= 1'b1;
              cnt       <= cnt + CW'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            div_clr   <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            res_rem   <= div_rem;
            res_zero  <= (div_rem == 9'h000);
            res_err   <= (div_count != NSHIFT_C);
            res_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
